mux_16t1_arbiter: RTL
=====================

Name: mux_16t1_arbiter

Overview:
- Round-robin arbiter that shares one n-bit result bus among 16 requesters (register file, ALU, scratch RAM, I/O ports, …) on the RAT datapath.
- Owns the SEL input of an internal mux_16t1_nb instance and registers the grant.
- Presents the selected word to a single consumer with a VALID/RDY handshake.
- Bounds each tenure to MAX_BEATS accepted transfers, so no requester can starve the others.

Parameters:
- n, 8: data width of each requester word and of DOUT.
- MAX_BEATS, 4: maximum accepted transfers per grant tenure; legal range 1..16.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ  in  16  request vector; bit i high means requester i wants the bus. A requester holds REQ high until its transfers are accepted.
- DIN  in  16*n  flattened requester data; requester i occupies bits [i*n +: n].
- RDY  in  1  consumer ready.
- GNT  out  16  registered one-hot grant; all zero when idle.
- SEL  out  4  registered index of the granted requester; also drives the mux.
- VALID  out  1  registered; DOUT holds a valid word for the granted requester.
- DOUT  out  n  mux output gated by VALID; zero when VALID=0.
- BEAT  out  clog2(MAX_BEATS+1)  count of beats accepted in the current tenure.

Behaviour:
- Reset (RST_N=0, asynchronous, immediate, also mid-tenure):
  - state=IDLE, GNT=0, SEL=0, VALID=0, BEAT=0, PTR=0.
  - DOUT=0 while reset is held.
- Internal pointer PTR[3:0]: the first index searched, then PTR+1 … PTR+15 mod 16.
- States: IDLE and BUSY.
- IDLE:
  - If REQ != 0 at an edge, pick the winner w = first set bit searching from PTR upward with wrap.
  - Load SEL=w, GNT=1<<w, VALID=1, BEAT=0, state=BUSY.
  - Latency: REQ set in cycle t gives GNT/VALID high in cycle t+1.
  - If REQ == 0, the block stays in IDLE.
- BUSY:
  - DOUT = DIN[SEL] combinationally through the mux.
  - A beat is accepted at an edge where VALID & RDY.
  - On each accepted beat, BEAT increments.
- Release conditions, evaluated at each edge in BUSY:
  - (a) REQ[SEL]=0: abort, no beat counted this edge even if RDY=1.
  - (b) Accepted beat with BEAT==MAX_BEATS-1: tenure complete.
- On release:
  - PTR = SEL+1 mod 16, so 15 wraps to 0.
  - Re-arbitrate the same edge over the current REQ using the new PTR.
  - If there is a winner, load the new SEL/GNT, keep VALID=1, set BEAT=0, stay in BUSY. This gives back-to-back tenures with no idle bubble.
  - If there is no winner: state=IDLE, GNT=0, VALID=0, BEAT=0; SEL holds its last value.
- Continuing requester: after a completed tenure, the same requester that still requests is regranted only if no other bit is set in REQ, because it now has lowest priority.
- RDY=0 in BUSY: everything holds; DOUT follows DIN[SEL] live, and the requester must keep its data stable.
- Requests arriving while BUSY do not disturb the current tenure. They are considered at the next release.
- MAX_BEATS=1: every accepted beat releases the grant, giving pure per-word round robin.
- Invariants, checked by assertion:
  - GNT is one-hot or zero.
  - GNT != 0 if and only if VALID.
  - When VALID, GNT == 1<<SEL.
  - BEAT < MAX_BEATS.

Decomposition:
- Package mux_arb_pkg:
  - state enum {IDLE, BUSY}.
  - NUM_REQ=16 and SEL_W=4.
  - Function rr_pick(req, ptr), returning the winner index plus a found flag.
- Sub-module: one mux_16t1_nb #(.n(n)) instance.
  - D0..D15 come from the DIN slices, SEL comes from the registered SEL, D_OUT is gated by VALID to form DOUT.
- The arbiter FSM, pointer and beat counter stay in this module.

Test Plan:
- Reset and idle:
  - Stimulus: RST_N=0 with REQ=16'hFFFF, then release with REQ=0.
  - Expect GNT=0, VALID=0, DOUT=0, BEAT=0 for 5 cycles.
  - Then drop RST_N mid-tenure and expect all outputs to clear the same cycle.
- Single requester, full tenure:
  - Stimulus: REQ=16'h0020, DIN slice 5=8'hA5, RDY=1, MAX_BEATS=4.
  - Expect GNT=16'h0020, SEL=5, DOUT=8'hA5 one cycle after REQ, with BEAT counting 0,1,2,3.
  - Because only requester 5 is requesting, it is regranted at the release edge: BEAT restarts at 0 with no idle cycle, and PTR becomes 6.
- Round-robin fairness with wrap:
  - Stimulus: REQ=16'h8003 constant, RDY=1, MAX_BEATS=1, starting with PTR=0.
  - Expect grant order 0,1,15,0,1,15, back-to-back with VALID continuously high.
- Backpressure:
  - Stimulus: grant to requester 3, RDY=0 for 6 cycles, then RDY=1.
  - Expect GNT, SEL and BEAT frozen while RDY=0, then BEAT increments on each RDY=1 edge.
- Abort:
  - Stimulus: requester 7 granted with BEAT=2, then REQ[7] drops while REQ[2]=1 and RDY=1.
  - Expect no beat counted that edge, next-cycle GNT=16'h0004, PTR=8.
  - With REQ=0 after the abort, expect IDLE: VALID=0 and DOUT=0.
- Late arrival:
  - Stimulus: REQ[9] asserts while requester 4 is mid-tenure.
  - Expect requester 4 to complete its MAX_BEATS beats before the grant moves to 9.

Source files
------------

// File: rtl/mux_16t1_arbiter_pkg.sv
// mux_arb_pkg: shared types, sizes and the round-robin pick function for the 16:1 arbiter.
package mux_arb_pkg;
    localparam int NUM_REQ = 16;
    localparam int SEL_W = 4;
    typedef enum logic {IDLE, BUSY} state_t;
    typedef struct packed {
        logic found;
        logic [SEL_W-1:0] idx;
    } pick_t;
    // Scan from the highest offset down so the last hit is the first set bit at or after ptr.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
        pick_t p;
        logic [SEL_W-1:0] i;
        p = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            i = ptr + SEL_W'(k);
            if (req[i]) p = '{found: 1'b1, idx: i};
        end
        return p;
    endfunction
endpackage

// File: rtl/mux_16t1_arbiter_if.sv
// mux_16t1_arbiter_if: requester/consumer bus of the arbiter; slave is the arbiter side.
interface mux_16t1_arbiter_if import mux_arb_pkg::*; #(parameter int n = 8, parameter int MAX_BEATS = 4);
    localparam int BW = $clog2(MAX_BEATS + 1);
    logic [NUM_REQ-1:0] REQ;
    logic [NUM_REQ*n-1:0] DIN;
    logic RDY;
    logic [NUM_REQ-1:0] GNT;
    logic [SEL_W-1:0] SEL;
    logic VALID;
    logic [n-1:0] DOUT;
    logic [BW-1:0] BEAT;
    modport master(output REQ, DIN, RDY, input GNT, SEL, VALID, DOUT, BEAT);
    modport slave(input REQ, DIN, RDY, output GNT, SEL, VALID, DOUT, BEAT);
endinterface

// File: rtl/mux_16t1_arbiter_mux.sv
// mux_16t1_nb: plain 16-to-1 n-bit word multiplexer.
module mux_16t1_nb #(parameter int n = 8) (
    input  logic [n-1:0] D0, D1, D2, D3, D4, D5, D6, D7,
    input  logic [n-1:0] D8, D9, D10, D11, D12, D13, D14, D15,
    input  logic [3:0]   SEL,
    output logic [n-1:0] D_OUT
);
    logic [n-1:0] d [16];
    assign d = '{D0, D1, D2, D3, D4, D5, D6, D7, D8, D9, D10, D11, D12, D13, D14, D15};
    assign D_OUT = d[SEL];
endmodule

// File: rtl/mux_16t1_arbiter.sv
// mux_16t1_arbiter: round-robin owner of a 16:1 result mux with VALID/RDY output and bounded tenures.
module mux_16t1_arbiter import mux_arb_pkg::*; #(parameter int n = 8, parameter int MAX_BEATS = 4) (
    input logic CLK,
    input logic RST_N,
    mux_16t1_arbiter_if.slave bus
);
    localparam int BW = $clog2(MAX_BEATS + 1);
    state_t state, state_n;
    logic [SEL_W-1:0] ptr, ptr_n, sel, sel_n;
    logic [NUM_REQ-1:0] gnt, gnt_n;
    logic valid, valid_n;
    logic [BW-1:0] beat, beat_n;
    logic [n-1:0] mux_out;
    logic busy, abort, done;
    pick_t pick;

    assign busy = state == BUSY;
    assign abort = busy && !bus.REQ[sel];
    assign done = busy && !abort && valid && bus.RDY && beat == BW'(MAX_BEATS - 1);
    // On release the search already starts past the outgoing owner, giving back-to-back tenures.
    assign pick = rr_pick(bus.REQ, busy ? sel + 4'd1 : ptr);

    always_comb begin
        state_n = state;
        ptr_n = ptr;
        sel_n = sel;
        gnt_n = gnt;
        valid_n = valid;
        beat_n = beat;
        if (!busy || abort || done) begin
            if (busy) ptr_n = sel + 4'd1;
            if (pick.found) begin
                state_n = BUSY;
                sel_n = pick.idx;
                gnt_n = NUM_REQ'(1) << pick.idx;
                valid_n = 1'b1;
                beat_n = '0;
            end else if (busy) begin
                state_n = IDLE;
                gnt_n = '0;
                valid_n = 1'b0;
                beat_n = '0;
            end
        end else if (valid && bus.RDY) beat_n = beat + BW'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            ptr <= '0;
            sel <= '0;
            gnt <= '0;
            valid <= 1'b0;
            beat <= '0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            sel <= sel_n;
            gnt <= gnt_n;
            valid <= valid_n;
            beat <= beat_n;
        end
    end

    mux_16t1_nb #(.n(n)) u_mux (
        .D0(bus.DIN[0*n +: n]),   .D1(bus.DIN[1*n +: n]),   .D2(bus.DIN[2*n +: n]),   .D3(bus.DIN[3*n +: n]),
        .D4(bus.DIN[4*n +: n]),   .D5(bus.DIN[5*n +: n]),   .D6(bus.DIN[6*n +: n]),   .D7(bus.DIN[7*n +: n]),
        .D8(bus.DIN[8*n +: n]),   .D9(bus.DIN[9*n +: n]),   .D10(bus.DIN[10*n +: n]), .D11(bus.DIN[11*n +: n]),
        .D12(bus.DIN[12*n +: n]), .D13(bus.DIN[13*n +: n]), .D14(bus.DIN[14*n +: n]), .D15(bus.DIN[15*n +: n]),
        .SEL(sel),
        .D_OUT(mux_out)
    );

    assign bus.GNT = gnt;
    assign bus.SEL = sel;
    assign bus.VALID = valid;
    assign bus.BEAT = beat;
    assign bus.DOUT = valid ? mux_out : '0;

    assert property (@(posedge CLK) disable iff (!RST_N) $onehot0(gnt));
    assert property (@(posedge CLK) disable iff (!RST_N) (gnt != '0) == valid);
    assert property (@(posedge CLK) disable iff (!RST_N) !valid || gnt == (NUM_REQ'(1) << sel));
    assert property (@(posedge CLK) disable iff (!RST_N) beat < BW'(MAX_BEATS));
endmodule
